// File: rtl/serial_in_pkg.sv
// Shared types and helpers for the UART receive path.
package serial_in_pkg;

    localparam int data_bits = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Rounded to the nearest whole clock so the bit period error stays symmetric.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer for asynchronous board inputs; resets to the idle-high level.
module sync_ff #(
    parameter int stages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [stages-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= '1;
        else
            sync_q <= {sync_q[stages-2:0], d};
    end

    assign q = sync_q[stages-1];

endmodule

// File: rtl/serial_in.sv
// 8N1 UART receiver with a single-entry valid/ready holding register.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | checking the start bit at its centre
// DATA  | sampling the 8 data bits, LSB first
// STOP  | sampling the stop bit, then loading or discarding the byte
// BREAK | framing error seen, waiting for the line to return high
module serial_in
    import serial_in_pkg::*;
#(
    parameter int clks_per_bit = calc_clks_per_bit(50_000_000, 115_200),
    parameter int sync_stages  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       ready,
    input  logic       err_clr,
    output logic [7:0] char,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int cnt_w = $clog2(clks_per_bit);
    localparam int idx_w = $clog2(data_bits);
    localparam logic [cnt_w-1:0] cnt_half = cnt_w'(clks_per_bit / 2);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(clks_per_bit - 1);
    localparam logic [idx_w-1:0] idx_last = idx_w'(data_bits - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [cnt_w-1:0]     cnt;
    logic [idx_w-1:0]     bit_idx;
    logic [data_bits-1:0] shift_q;
    logic [sync_stages-1:0] flush_q;
    logic                 armed;

    sync_ff #(.stages(sync_stages)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rx),
        .q   (rx_s)
    );

    // The synchronizer resets high, so its output is only trusted once the
    // reset value has drained; a frame must then see the line high first.
    always_ff @(posedge clk) begin
        if (rst)
            flush_q <= '0;
        else
            flush_q <= {flush_q[sync_stages-2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            armed     <= 1'b0;
            char      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (valid && ready)
                valid <= 1'b0;
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!armed) begin
                        if (flush_q[sync_stages-1] && rx_s)
                            armed <= 1'b1;
                    end else if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == cnt_half) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == cnt_last) begin
                        cnt              <= '0;
                        shift_q[bit_idx] <= rx_s;
                        if (bit_idx == idx_last)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == cnt_last) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else begin
                            state <= IDLE;
                            if (!valid || ready) begin
                                char  <= shift_q;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_in.sv
// Scoreboard bench for serial_in: stimulus pushes expected bytes, a monitor pops on each new byte.
module tb_serial_in;

    localparam int cpb = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] char;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic valid_prev = 1'b0;
    logic xfer_pending = 1'b0;

    serial_in #(.clks_per_bit(cpb), .sync_stages(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .ready     (ready),
        .err_clr   (err_clr),
        .char      (char),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame starts on the current cycle; returns one bit-time after the stop bit began.
    task automatic send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            tick(cpb);
        end
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    // A byte is newly presented when valid rises or stays high across a transfer.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                valid_prev   = 1'b0;
                xfer_pending = 1'b0;
            end else begin
                if (valid && (!valid_prev || xfer_pending)) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %02h, none expected", char);
                    end else begin
                        exp = exp_q.pop_front();
                        check("sb_char", char, exp);
                    end
                end
                valid_prev   = valid;
                xfer_pending = valid && ready;
            end
        end
    end

    initial begin
        tick(3);
        check("rst_char", char, 8'h00);
        check("rst_valid", {7'b0, valid}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_flags", {6'b0, frame_err, overrun}, 8'h00);
        rst = 1'b0;
        tick(10);

        // nominal byte, consumer idle
        exp_q.push_back(8'h41);
        send(8'h41, 1'b1);
        check("nom_valid", {7'b0, valid}, 8'h01);
        check("nom_flags", {6'b0, frame_err, overrun}, 8'h00);
        pulse_ready();
        check("nom_consumed", {7'b0, valid}, 8'h00);
        check("nom_char_hold", char, 8'h41);
        tick(5);

        // back-to-back with ready exactly at the second stop sample
        exp_q.push_back(8'h2B);
        exp_q.push_back(8'h2D);
        fork
            begin
                send(8'h2B, 1'b1);
                send(8'h2D, 1'b1);
            end
            begin
                tick(2 * 10 * cpb - 1);
                pulse_ready();
            end
        join
        check("b2b_char", char, 8'h2D);
        check("b2b_valid", {7'b0, valid}, 8'h01);
        check("b2b_overrun", {7'b0, overrun}, 8'h00);
        pulse_ready();
        check("b2b_drained", {7'b0, valid}, 8'h00);
        tick(5);

        // overrun
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1);
        send(8'hAA, 1'b1);
        check("ovr_char", char, 8'h55);
        check("ovr_flag", {7'b0, overrun}, 8'h01);
        check("ovr_valid", {7'b0, valid}, 8'h01);
        pulse_err_clr();
        check("ovr_cleared", {7'b0, overrun}, 8'h00);
        pulse_ready();
        check("ovr_drained", {7'b0, valid}, 8'h00);
        tick(5);

        // framing error followed by held-low line
        send(8'h33, 1'b0);
        tick(40);
        check("frm_flag", {7'b0, frame_err}, 8'h01);
        check("frm_valid", {7'b0, valid}, 8'h00);
        check("frm_busy_break", {7'b0, busy}, 8'h01);
        uart_rx = 1'b1;
        tick(10);
        check("frm_idle", {7'b0, busy}, 8'h00);
        exp_q.push_back(8'h34);
        send(8'h34, 1'b1);
        check("frm_next_valid", {7'b0, valid}, 8'h01);
        check("frm_next_char", char, 8'h34);
        check("frm_sticky", {7'b0, frame_err}, 8'h01);
        pulse_ready();
        pulse_err_clr();
        check("frm_cleared", {7'b0, frame_err}, 8'h00);
        tick(5);

        // 2-clk glitch
        uart_rx = 1'b0;
        tick(2);
        uart_rx = 1'b1;
        tick(3);
        check("gl_busy_start", {7'b0, busy}, 8'h01);
        tick(20);
        check("gl_busy_idle", {7'b0, busy}, 8'h00);
        check("gl_no_byte", {7'b0, valid}, 8'h00);

        // reset in the middle of a frame, line still low on release
        uart_rx = 1'b0;
        tick(20);
        check("rstmid_busy_pre", {7'b0, busy}, 8'h01);
        rst = 1'b1;
        tick(3);
        check("rstmid_char", char, 8'h00);
        check("rstmid_outs", {4'b0, valid, frame_err, overrun, busy}, 8'h00);
        rst = 1'b0;
        tick(20);
        check("rstmid_low_ignored", {7'b0, busy}, 8'h00);
        uart_rx = 1'b1;
        tick(10);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1);
        check("rstmid_next_char", char, 8'h7E);
        check("rstmid_next_valid", {7'b0, valid}, 8'h01);
        pulse_ready();
        tick(5);

        check("sb_empty", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_in.md
Name: serial_in

Overview:
- UART receiver (8N1, LSB first), the receive-side counterpart of the board's serial transmit path.
- Feeds the BF core's input instruction (`,`): delivers one received byte through a single-entry holding register with a valid/ready handshake.
- Runs on the fast board clock `clk`, not the divided core clock. The core samples `char`/`valid` and pulses `ready` when it consumes a byte.

Parameters:
- clks_per_bit, 434, board clock cycles per UART bit (50 MHz / 115200); minimum 4.
- sync_stages, 2, flip-flop stages on `uart_rx` before use; minimum 2.

Ports:
- clk  input  1  board clock
- rst  input  1  synchronous, active-high reset
- uart_rx  input  1  asynchronous serial line, idle high
- ready  input  1  consumer accepts `char` this cycle when `valid` is 1
- err_clr  input  1  clears sticky `frame_err` and `overrun`
- char  output  8  received byte; stable while `valid` is 1
- valid  output  1  holding register full
- frame_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte completed while holding register full and not being consumed
- busy  output  1  receiver not in IDLE

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - state IDLE, all counters 0.
  - Synchronizer flops 1.
  - `char` = 8'h00, `valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0.
- Reset mid-frame: abandons the frame. The next frame is detected only after the line is seen high, then falls again.
- The synchronized line is `rx_s`. All decisions use `rx_s` only.
- Bit counter: counts 0..clks_per_bit-1, then wraps to 0.
- IDLE:
  - On `rx_s` = 0, go to START and zero the counter.
  - `busy` = 0 in IDLE only.
- START:
  - At count = clks_per_bit/2 (integer divide), sample `rx_s`.
  - If 1: glitch. Return to IDLE with no flag set.
  - If 0: go to DATA, zero the counter and the bit index.
- DATA:
  - Each time the counter reaches clks_per_bit-1, zero it and sample `rx_s` into shift register bit[index] (LSB first).
  - After index 7 has been sampled, go to STOP.
- STOP, at count = clks_per_bit-1, sample `rx_s`:
  - If 1 and (`valid` = 0 or `ready` = 1 this cycle):
    - Load `char`; `valid` = 1 from the next cycle.
    - Go to IDLE.
  - If 1 and `valid` = 1 and `ready` = 0:
    - Discard the byte; set `overrun`.
    - Holding register unchanged.
    - Go to IDLE.
  - If 0:
    - Discard the byte; set `frame_err`.
    - Go to BREAK.
- BREAK: wait until `rx_s` = 1, then go to IDLE. Prevents a held-low line from generating frames.
- Handshake:
  - Transfer occurs on a cycle where `valid` = 1 and `ready` = 1.
  - After a transfer, `valid` = 0 next cycle, unless a new byte is loaded in the same cycle, in which case `valid` stays 1 with the new `char`.
  - `ready` while `valid` = 0 is ignored.
  - `char` holds its last value after consumption.
- Latency:
  - `valid` rises 1 clk after the stop-bit sample.
  - The stop-bit sample occurs sync_stages + clks_per_bit/2 + 9*clks_per_bit clks (approximately) after the start-bit falling edge.
- Sticky flags: `err_clr` clears both. If `err_clr` and a set event coincide, the set wins.

Decomposition:
- Package serial_in_pkg:
  - enum rx_state_t {IDLE, START, DATA, STOP, BREAK}.
  - Localparam data_bits = 8.
  - Function calc_clks_per_bit(clk_hz, baud).
- Sub-module: sync_ff, a parameterised N-stage synchronizer with reset value 1, reusable for other asynchronous board inputs.
- FSM, counters, shift register and holding register stay in serial_in.

Test Plan:
- Simulation uses clks_per_bit = 8.
- Nominal byte: send 0x41 with `ready` low -> `valid` = 1, `char` = 0x41, no flags. Pulse `ready` -> `valid` = 0 next cycle.
- Back-to-back: send 0x2B then 0x2D; pulse `ready` for one cycle exactly at the second stop sample -> `char` = 0x2D, `valid` stays 1, `overrun` = 0.
- Overrun: send 0x55, then 0xAA, no `ready` -> `char` = 0x55, `overrun` = 1. Pulse `err_clr` -> `overrun` = 0.
- Framing: send 0x33 with stop bit 0, then hold the line low 40 clks -> `frame_err` = 1, `valid` = 0. No further bytes until the line goes high; a following valid 0x34 is received correctly.
- Glitch and reset: drive a 2-clk low pulse -> no byte received, `busy` back to 0. Assert `rst` during DATA of a byte -> all outputs 0, next full byte 0x7E received correctly.
